// File: rtl/mult_test_sequencer.sv
//-----------------------------------------------------------------------------
// mult_test_sequencer
//
// Purpose:
//   Walks a multiplier under test through a block of N operand vectors. The
//   operand RAMs (A and B share one address) are read at 0..N-1 on N
//   consecutive cycles. The matching result RAM writes follow exactly LATENCY
//   cycles later through a shift pipeline, so the result address always lines
//   up with the operand address that produced it. The number of cycles spent
//   in RUN and DRAIN is counted so software can read back the run time.
//
// Parameters:
//   ADDR_WIDTH  width of operand and result RAM addresses
//   LATENCY     cycles from operand read address to result write (1..64)
//   CNT_WIDTH   width of the run cycle counter
//
// Ports:
//   clock        single rising-edge clock
//   resetn       asynchronous active-low reset
//   start        one-cycle request to begin a run (accepted in IDLE/DONE only)
//   abort        ends any run; wins over start
//   num_tests    vector count N, 0..2^ADDR_WIDTH, sampled on the accepting edge
//   rd_addr      operand RAM read address, held while rd_en is low
//   rd_en        rd_addr is valid this cycle
//   wr_addr      result RAM write address, held while wr_en is low
//   wr_en        result RAM write enable
//   busy         high while in RUN or DRAIN
//   done         high while in DONE
//   cycle_count  RUN+DRAIN cycles of the last or current run, saturating
//-----------------------------------------------------------------------------
module mult_test_sequencer #(
    parameter int ADDR_WIDTH = 11,
    parameter int LATENCY    = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   num_tests,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Seven bits is enough to count the largest legal drain of 64 cycles.
    localparam int                   DRAIN_W    = 7;
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    state_t              state;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic                  run_zero;

    // Write pipeline: one enable bit and one address per stage of latency.
    logic [LATENCY-1:0]    pipe_en;
    logic [ADDR_WIDTH-1:0] pipe_addr [LATENCY];

    assign run_zero = (num_tests == '0);

    //-------------------------------------------------------------------------
    // Main sequencer. The last read address is stored as N-1 truncated to
    // ADDR_WIDTH bits, so N = 2^ADDR_WIDTH stops at the all-ones address
    // rather than wrapping. Abort has top priority after reset, which also
    // drops a start presented in the same cycle. cycle_count is left alone
    // on abort and in IDLE/DONE so the last value stays readable.
    //-------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            last_addr   <= '0;
            drain_cnt   <= '0;
        end else if (abort) begin
            state     <= IDLE;
            rd_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cycle_count <= '0;
                        drain_cnt   <= '0;
                        if (run_zero) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            rd_en     <= 1'b1;
                            rd_addr   <= '0;
                            last_addr <= ADDR_WIDTH'(num_tests - (ADDR_WIDTH + 1)'(1));
                        end
                    end
                end

                RUN: begin
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_WIDTH'(1);
                    end
                    if (rd_addr == last_addr) begin
                        rd_en     <= 1'b0;
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(1);
                    end
                end

                DRAIN: begin
                    if (cycle_count != CNT_MAX) begin
                        cycle_count <= cycle_count + CNT_WIDTH'(1);
                    end
                    // The final write leaves the pipeline in the last DRAIN cycle.
                    if (drain_cnt == DRAIN_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // Write pipeline. Each stage only loads a new address when the enable
    // entering it is set, so the last stage's address (wr_addr) holds its
    // previous value whenever wr_en is low. Abort and reset both flush every
    // enable bit so no in-flight write can escape.
    //-------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe_en <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pipe_addr[k] <= '0;
            end
        end else if (abort) begin
            pipe_en <= '0;
        end else begin
            pipe_en[0] <= rd_en;
            if (rd_en) begin
                pipe_addr[0] <= rd_addr;
            end
            for (int k = 1; k < LATENCY; k++) begin
                pipe_en[k] <= pipe_en[k-1];
                if (pipe_en[k-1]) begin
                    pipe_addr[k] <= pipe_addr[k-1];
                end
            end
        end
    end

    assign wr_en   = pipe_en[LATENCY-1];
    assign wr_addr = pipe_addr[LATENCY-1];

endmodule

// File: tb/tb_mult_test_sequencer.sv
//-----------------------------------------------------------------------------
// tb_mult_test_sequencer
//
// Purpose:
//   Self-checking bench for mult_test_sequencer with ADDR_WIDTH=11,
//   LATENCY=6. A table of runs (N, expected cycle count, expected cycle at
//   which done rises, expected final addresses) is applied one after another;
//   abort and reset-during-drain are exercised by hand-written sequences.
//   Inputs are driven and outputs sampled on the falling clock edge.
//-----------------------------------------------------------------------------
module tb_mult_test_sequencer;

    localparam int AW  = 11;
    localparam int LAT = 6;
    localparam int CW  = 32;

    logic          clock;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [AW:0]   num_tests;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int n;
        int exp_cc;
        int exp_done_cyc;
        int exp_last;
        bit collide;
    } vec_t;

    vec_t vecs [8];

    mult_test_sequencer #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT),
        .CNT_WIDTH (CW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .num_tests  (num_tests),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .busy       (busy),
        .done       (done),
        .cycle_count(cycle_count)
    );

    // 10 ns clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compare one value and log a failure line if it differs.
    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Pulse start with count n and let the run go to DONE, tracking every
    // read and write. With collide set, extra starts (with a different count)
    // are pulsed once in RUN and once in DRAIN and must be ignored.
    task automatic apply_stimulus(input vec_t v);
        int  rd_cnt      = 0;
        int  wr_cnt      = 0;
        int  rd_addr_err = 0;
        int  wr_addr_err = 0;
        int  first_rd    = -1;
        int  last_rd     = -1;
        int  first_wr    = -1;
        int  busy_cyc    = 0;
        int  done_cyc    = -1;
        int  done_at_0   = 0;
        int  budget      = v.n + LAT + 40;
        bit  done_seen   = 0;

        num_tests = (AW+1)'(v.n);
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;

        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc == 0) done_at_0 = int'(done);
            if (done) begin
                done_seen = 1;
                done_cyc  = cyc;
                break;
            end
            if (busy) busy_cyc++;
            if (rd_en) begin
                if (int'(rd_addr) != rd_cnt) rd_addr_err++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                rd_cnt++;
            end
            if (wr_en) begin
                if (int'(wr_addr) != wr_cnt) wr_addr_err++;
                if (first_wr < 0) first_wr = cyc;
                wr_cnt++;
            end
            start     = v.collide && (cyc == 1 || cyc == v.n + 2);
            num_tests = start ? (AW+1)'(9) : (AW+1)'(v.n);
            @(negedge clock);
        end
        start = 1'b0;

        check_output($sformatf("n%0d_done_seen", v.n), done_seen, 1);
        check_output($sformatf("n%0d_done_cycle", v.n), done_cyc, v.exp_done_cyc);
        check_output($sformatf("n%0d_rd_count", v.n), rd_cnt, v.n);
        check_output($sformatf("n%0d_wr_count", v.n), wr_cnt, v.n);
        check_output($sformatf("n%0d_rd_addr_seq_errs", v.n), rd_addr_err, 0);
        check_output($sformatf("n%0d_wr_addr_seq_errs", v.n), wr_addr_err, 0);
        check_output($sformatf("n%0d_busy_cycles", v.n), busy_cyc, v.exp_cc);
        check_output($sformatf("n%0d_cycle_count", v.n), cycle_count, v.exp_cc);
        if (v.n > 0) begin
            check_output($sformatf("n%0d_done_cleared", v.n), done_at_0, 0);
            check_output($sformatf("n%0d_first_rd_cycle", v.n), first_rd, 0);
            check_output($sformatf("n%0d_rd_contiguous", v.n), last_rd - first_rd + 1, v.n);
            check_output($sformatf("n%0d_wr_delay", v.n), first_wr - first_rd, LAT);
            check_output($sformatf("n%0d_rd_addr_held", v.n), rd_addr, v.exp_last);
            check_output($sformatf("n%0d_wr_addr_held", v.n), wr_addr, v.exp_last);
        end

        // DONE must persist and the counter must hold.
        repeat (3) @(negedge clock);
        check_output($sformatf("n%0d_done_persist", v.n), done, 1);
        check_output($sformatf("n%0d_cc_hold", v.n), cycle_count, v.exp_cc);
        check_output($sformatf("n%0d_busy_done", v.n), busy, 0);
    endtask

    // Watch for stray activity over a window where the block must be quiet.
    task automatic watch_quiet(input string name, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (wr_en || rd_en || busy || done) bad++;
        end
        check_output(name, bad, 0);
    endtask

    initial begin
        // n, expected cycle_count, done cycle, last address, collide
        vecs[0] = '{n: 4,    exp_cc: 10,   exp_done_cyc: 10,   exp_last: 3,    collide: 0};
        vecs[1] = '{n: 1,    exp_cc: 7,    exp_done_cyc: 7,    exp_last: 0,    collide: 0};
        vecs[2] = '{n: 0,    exp_cc: 0,    exp_done_cyc: 0,    exp_last: 0,    collide: 0};
        vecs[3] = '{n: 2048, exp_cc: 2054, exp_done_cyc: 2054, exp_last: 2047, collide: 0};
        vecs[4] = '{n: 37,   exp_cc: 43,   exp_done_cyc: 43,   exp_last: 36,   collide: 0};
        vecs[5] = '{n: 3,    exp_cc: 9,    exp_done_cyc: 9,    exp_last: 2,    collide: 1};
        vecs[6] = '{n: 2,    exp_cc: 8,    exp_done_cyc: 8,    exp_last: 1,    collide: 0};
        vecs[7] = '{n: 5,    exp_cc: 11,   exp_done_cyc: 11,   exp_last: 4,    collide: 0};

        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        num_tests = '0;
        repeat (3) @(negedge clock);

        // Reset state.
        check_output("rst_rd_en", rd_en, 0);
        check_output("rst_wr_en", wr_en, 0);
        check_output("rst_rd_addr", rd_addr, 0);
        check_output("rst_wr_addr", wr_addr, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_done", done, 0);
        check_output("rst_cycle_count", cycle_count, 0);
        resetn = 1'b1;
        watch_quiet("idle_quiet", 3);

        // Table of runs, back to back (each start taken from DONE).
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Abort on the 3rd RUN cycle of an N=100 run, with start also high.
        num_tests = (AW+1)'(100);
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check_output("abort_pre_busy", busy, 1);
        check_output("abort_pre_rd_addr", rd_addr, 2);
        abort     = 1'b1;
        start     = 1'b1;
        num_tests = (AW+1)'(5);
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        check_output("abort_busy", busy, 0);
        check_output("abort_rd_en", rd_en, 0);
        check_output("abort_done", done, 0);
        check_output("abort_wr_en", wr_en, 0);
        check_output("abort_cycle_count", cycle_count, 2);
        check_output("abort_rd_addr_held", rd_addr, 2);
        watch_quiet("abort_quiet", 20);
        check_output("abort_cc_still", cycle_count, 2);

        // Reset pulled low in DRAIN while writes are in flight.
        num_tests = (AW+1)'(10);
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(negedge clock);
        check_output("rstmid_pre_busy", busy, 1);
        check_output("rstmid_pre_wr_en", wr_en, 1);
        #2 resetn = 1'b0;
        #1;
        check_output("rstmid_rd_en", rd_en, 0);
        check_output("rstmid_wr_en", wr_en, 0);
        check_output("rstmid_rd_addr", rd_addr, 0);
        check_output("rstmid_wr_addr", wr_addr, 0);
        check_output("rstmid_busy", busy, 0);
        check_output("rstmid_done", done, 0);
        check_output("rstmid_cycle_count", cycle_count, 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        watch_quiet("rstmid_quiet", 20);

        // First run after reset must behave like one after power-up.
        apply_stimulus(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute guard so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=%0d expected=%0d", 0, 1);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
